// File: rtl/pe_output_collector_pkg.sv
// Shared definitions for the PE output collector: drain FSM encodings and the
// words-per-beat helper macro used to size the beat mux.
`ifndef PE_COLL_WPB
`define PE_COLL_WPB(out_w, op_w) ((out_w) / (op_w))
`endif

package pe_output_collector_pkg;

  typedef enum logic {
    COLL_IDLE  = 1'b0,
    COLL_DRAIN = 1'b1
  } coll_state_t;

  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/collector_bank.sv
// One ping-pong bank: NUM_PE captured words plus a full flag, read back one
// OUT_WIDTH beat at a time through a mux selected by the drain beat counter.
module collector_bank #(
  parameter int NUM_PE    = 8,
  parameter int OP_WIDTH  = 16,
  parameter int OUT_WIDTH = 64,
  parameter int BEAT_W    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture,
  input  logic [NUM_PE*OP_WIDTH-1:0] capture_data,
  input  logic                       clear,
  input  logic [BEAT_W-1:0]          beat_sel,
  output logic                       full,
  output logic [OUT_WIDTH-1:0]       beat_data
);

  localparam int WPB    = `PE_COLL_WPB(OUT_WIDTH, OP_WIDTH);
  localparam int NBEATS = NUM_PE / WPB;

  logic [OUT_WIDTH-1:0] beats [NBEATS];

  // A capture landing on the cycle the bank frees wins, so the bank stays full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NBEATS; k++) begin
        beats[k] <= capture_data[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign beat_data = beats[beat_sel];

endmodule

// File: rtl/pe_output_collector.sv
// Ping-pong capture of PE results with mask (and ReLU when PE_COLLECTOR_RELU_EN
// is defined), serialized as OUT_WIDTH beats on a valid/ready stream.
module pe_output_collector
  import pe_output_collector_pkg::*;
#(
  parameter int NUM_PE    = 8,
  parameter int OP_WIDTH  = 16,
  parameter int OUT_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pe_write_valid,
  input  logic [NUM_PE*OP_WIDTH-1:0] pe_write_data,
  input  logic [NUM_PE-1:0]          pe_mask,
  output logic                       pe_stall,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow
);

  localparam int WPB    = `PE_COLL_WPB(OUT_WIDTH, OP_WIDTH);
  localparam int NBEATS = NUM_PE / WPB;
  localparam int BEAT_W = beat_w(NBEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

`ifdef PE_COLLECTOR_RELU_EN
  function automatic logic signed [OP_WIDTH-1:0] relu(input logic signed [OP_WIDTH-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
`endif

  logic [NUM_PE*OP_WIDTH-1:0] capture_word;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    logic signed [OP_WIDTH-1:0] word;
    assign word = pe_write_data[i*OP_WIDTH +: OP_WIDTH];
`ifdef PE_COLLECTOR_RELU_EN
    assign capture_word[i*OP_WIDTH +: OP_WIDTH] = pe_mask[i] ? relu(word) : '0;
`else
    assign capture_word[i*OP_WIDTH +: OP_WIDTH] = pe_mask[i] ? word : '0;
`endif
  end

  coll_state_t          state, state_nxt;
  logic                 rd_sel, rd_sel_nxt;
  logic                 wr_sel, wr_sel_nxt;
  logic                 overflow_nxt;
  logic [BEAT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [1:0]           full, capture, clear;
  logic [OUT_WIDTH-1:0] bank_data [2];
  logic                 handshake, last_hs, accept;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    collector_bank #(
      .NUM_PE    (NUM_PE),
      .OP_WIDTH  (OP_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .BEAT_W    (BEAT_W)
    ) u_bank (
      .clk          (clk),
      .reset        (reset),
      .capture      (capture[b]),
      .capture_data (capture_word),
      .clear        (clear[b]),
      .beat_sel     (beat_cnt),
      .full         (full[b]),
      .beat_data    (bank_data[b])
    );
  end

  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && (beat_cnt == LAST_BEAT);
  assign clear     = last_hs ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
  // The target bank counts as free if it completes its last beat this cycle.
  assign accept    = pe_write_valid && (!full[wr_sel] || clear[wr_sel]);
  assign capture   = accept ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    rd_sel_nxt   = rd_sel;
    wr_sel_nxt   = wr_sel ^ accept;
    overflow_nxt = overflow | (pe_write_valid && !accept);
    case (state)
      COLL_IDLE: begin
        if (full[rd_sel]) state_nxt = COLL_DRAIN;
      end
      COLL_DRAIN: begin
        if (last_hs) begin
          beat_cnt_nxt = '0;
          rd_sel_nxt   = ~rd_sel;
          state_nxt    = full[~rd_sel] ? COLL_DRAIN : COLL_IDLE;
        end else if (handshake) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = COLL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLL_IDLE;
      beat_cnt <= '0;
      rd_sel   <= 1'b0;
      wr_sel   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      rd_sel   <= rd_sel_nxt;
      wr_sel   <= wr_sel_nxt;
      overflow <= overflow_nxt;
    end
  end

  assign out_valid = (state == COLL_DRAIN);
  assign out_last  = out_valid && (beat_cnt == LAST_BEAT);
  assign out_data  = out_valid ? bank_data[rd_sel] : '0;
  assign pe_stall  = &full;

endmodule
